readout_packetizer: RTL and testbench

Frames sensor readout words into byte packets for the UART transmit path. It sits directly upstream of the UART transmitter. On the sensor side it accepts one channel-tagged word per frame through a valid/ready handshake. On the UART side it drives the byte/write-enable pair into the transmitter FIFO, honouring that FIFO's full flag as back-pressure.

---
 rtl/readout_pkg.sv | 22 ++
 rtl/readout_packetizer.sv | 137 +++++++++++++
 tb/tb_readout_packetizer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/readout_pkg.sv
// Shared definitions for the readout packetizer: state encoding, default
// framing bytes and the frame-length helper.
package readout_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HEAD = 3'd1,
        ST_CHAN = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_TAIL = 3'd5
    } state_t;

    localparam logic [7:0] HEADER_DEF  = 8'hA5;
    localparam logic [7:0] TRAILER_DEF = 8'h5A;

    // Bytes on the wire per frame: header, channel, data, checksum, trailer.
    function automatic int unsigned frame_len(input int unsigned data_bytes);
        return data_bytes + 4;
    endfunction

endpackage

// File: rtl/readout_packetizer.sv
// Frames channel-tagged readout words into HEADER/CHANNEL/DATA/CHECKSUM/TRAILER
// byte packets for the UART transmit FIFO, stalling on the FIFO full flag.
//
// state | meaning
// IDLE  | ready for a word, nothing presented to the transmitter
// HEAD  | presenting HEADER
// CHAN  | presenting zero-extended channel id
// DATA  | presenting word byte idx, MSB first
// CSUM  | presenting mod-256 sum of channel and data bytes
// TAIL  | presenting TRAILER; completion bumps the frame counter
module readout_packetizer
    import readout_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned CH_WIDTH   = 8,
    parameter logic [7:0]  HEADER     = HEADER_DEF,
    parameter logic [7:0]  TRAILER    = TRAILER_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    word_valid_i,
    input  logic [8*DATA_BYTES-1:0] word_data_i,
    input  logic [CH_WIDTH-1:0]     word_ch_i,
    output logic                    word_ready_o,
    input  logic                    tx_busy_i,
    output logic [7:0]              tx_data_o,
    output logic                    tx_en_o,
    output logic                    busy_o,
    output logic [15:0]             frame_cnt_o
);

    localparam int unsigned WW       = 8 * DATA_BYTES;
    localparam logic [2:0]  IDX_LAST = 3'(DATA_BYTES - 1);

    state_t            state_q, state_d;
    logic [WW-1:0]     word_q, word_d;
    logic [CH_WIDTH-1:0] ch_q, ch_d;
    logic [7:0]        csum_q, csum_d;
    logic [2:0]        idx_q, idx_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic [7:0]        chan_byte;
    logic [7:0]        data_byte;
    logic [WW-1:0]     word_shifted;

    // Shift the current byte to the top so MSB-first indexing needs no variable part-select.
    always_comb begin
        chan_byte               = '0;
        chan_byte[CH_WIDTH-1:0] = ch_q;
        word_shifted            = word_q << {idx_q, 3'b000};
        data_byte               = word_shifted[WW-1 -: 8];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            ch_q        <= '0;
            csum_q      <= '0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            ch_q        <= ch_d;
            csum_q      <= csum_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        ch_d         = ch_q;
        csum_d       = csum_q;
        idx_d        = idx_q;
        frame_cnt_d  = frame_cnt_q;
        word_ready_o = 1'b0;
        tx_en_o      = 1'b0;
        tx_data_o    = 8'h00;

        case (state_q)
            ST_IDLE: begin
                word_ready_o = 1'b1;
                if (word_valid_i) begin
                    word_d  = word_data_i;
                    ch_d    = word_ch_i;
                    csum_d  = '0;
                    idx_d   = '0;
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                tx_en_o   = ~tx_busy_i;
                tx_data_o = HEADER;
                if (tx_en_o) state_d = ST_CHAN;
            end
            ST_CHAN: begin
                tx_en_o   = ~tx_busy_i;
                tx_data_o = chan_byte;
                if (tx_en_o) begin
                    csum_d  = csum_q + chan_byte;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_en_o   = ~tx_busy_i;
                tx_data_o = data_byte;
                if (tx_en_o) begin
                    csum_d = csum_q + data_byte;
                    if (idx_q == IDX_LAST) state_d = ST_CSUM;
                    else                   idx_d   = idx_q + 3'd1;
                end
            end
            ST_CSUM: begin
                tx_en_o   = ~tx_busy_i;
                tx_data_o = csum_q;
                if (tx_en_o) state_d = ST_TAIL;
            end
            ST_TAIL: begin
                tx_en_o   = ~tx_busy_i;
                tx_data_o = TRAILER;
                if (tx_en_o) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_readout_packetizer.sv
// Scoreboard bench for readout_packetizer: expected bytes are queued by the
// stimulus from a frame model and popped by a monitor on every tx_en_o strike.
module tb_readout_packetizer;
    import readout_pkg::*;

    localparam int DB  = 4;
    localparam int CHW = 8;

    typedef struct packed {
        logic [7:0] b;
        logic       head;
        logic       tail;
    } exp_t;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            word_valid = 1'b0;
    logic [8*DB-1:0] word_data = '0;
    logic [CHW-1:0]  word_ch = '0;
    logic            word_ready;
    logic            tx_busy = 1'b0;
    logic [7:0]      tx_data;
    logic            tx_en;
    logic            busy;
    logic [15:0]     frame_cnt;

    readout_packetizer #(.DATA_BYTES(DB), .CH_WIDTH(CHW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .word_valid_i (word_valid),
        .word_data_i  (word_data),
        .word_ch_i    (word_ch),
        .word_ready_o (word_ready),
        .tx_busy_i    (tx_busy),
        .tx_data_o    (tx_data),
        .tx_en_o      (tx_en),
        .busy_o       (busy),
        .frame_cnt_o  (frame_cnt)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rdy_cnt = 0;
    int          head_cyc = 0, last_tail_cyc = 0, last_gap = 0, last_span = 0;
    int          strikes = 0, last_strikes = 0, rdy_at_tail = 0;
    logic [7:0]  frame_bytes[16];
    logic [15:0] exp_cnt = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Reference frame built straight from the wire format.
    function automatic logic [7:0] model_csum(input logic [CHW-1:0] ch, input logic [8*DB-1:0] d);
        int sum = int'(ch);
        for (int i = 0; i < DB; i++) sum += int'((d >> (8 * (DB - 1 - i))) & 32'hFF);
        return 8'(sum % 256);
    endfunction

    task automatic push_frame(input logic [CHW-1:0] ch, input logic [8*DB-1:0] d);
        exp_t e;
        e = '{b: 8'hA5, head: 1'b1, tail: 1'b0}; exp_q.push_back(e);
        e = '{b: 8'(ch), head: 1'b0, tail: 1'b0}; exp_q.push_back(e);
        for (int i = 0; i < DB; i++) begin
            e = '{b: 8'((d >> (8 * (DB - 1 - i))) & 32'hFF), head: 1'b0, tail: 1'b0};
            exp_q.push_back(e);
        end
        e = '{b: model_csum(ch, d), head: 1'b0, tail: 1'b0}; exp_q.push_back(e);
        e = '{b: 8'h5A, head: 1'b0, tail: 1'b1}; exp_q.push_back(e);
    endtask

    task automatic send_word(input logic [CHW-1:0] ch, input logic [8*DB-1:0] d, input bit keep);
        word_ch    = ch;
        word_data  = d;
        word_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (word_ready) begin
                push_frame(ch, d);
                @(posedge clk);
                #1;
                if (!keep) word_valid = 1'b0;
                return;
            end
        end
        fail_now("word_accept");
        word_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk);
            #1;
            tx_busy = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        tx_busy = 1'b0;
        if (!done) fail_now("frame_done");
    endtask

    initial begin
        exp_t e;
        logic [CHW-1:0]  rch;
        logic [8*DB-1:0] rd;
        bit found;

        fork
            forever begin
                @(negedge clk);
                cyc++;
                if (word_ready) rdy_cnt++;
                if (rstn && tx_en) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_byte: got %0h expected none", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_byte", 32'(tx_data), 32'(e.b));
                        if (e.head) begin
                            last_gap = cyc - last_tail_cyc;
                            head_cyc = cyc;
                            strikes  = 0;
                        end
                        if (strikes < 16) frame_bytes[strikes] = tx_data;
                        strikes++;
                        if (e.tail) begin
                            last_tail_cyc = cyc;
                            last_span     = cyc - head_cyc;
                            last_strikes  = strikes;
                            rdy_at_tail   = rdy_cnt;
                        end
                    end
                end
            end
        join_none

        // Reset state
        #2;
        chk("rst_ready", 32'(word_ready), 1);
        chk("rst_tx_en", 32'(tx_en), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Single frame
        send_word(8'h03, 32'h12345678, 1'b0);
        wait_idle(1'b0);
        exp_cnt++;
        chk("single_strikes", 32'(last_strikes), frame_len(DB));
        chk("single_span", 32'(last_span), frame_len(DB) - 1);
        chk("single_csum", 32'(frame_bytes[DB + 2]), 32'h17);
        chk("single_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("single_busy", 32'(busy), 0);

        // Checksum wrap
        send_word(8'hFF, 32'hFFFFFFFF, 1'b0);
        wait_idle(1'b0);
        exp_cnt++;
        chk("csum_wrap", 32'(frame_bytes[DB + 2]), 32'hFB);

        // Back-pressure in DATA at idx=1
        send_word(8'h03, 32'h12345678, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (tx_data == 8'h34) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!found) fail_now("reach_data_idx1");
        tx_busy = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_tx_en", 32'(tx_en), 0);
            chk("stall_tx_data", 32'(tx_data), 32'h34);
            @(posedge clk);
        end
        #1 tx_busy = 1'b0;
        wait_idle(1'b0);
        exp_cnt++;
        chk("stall_strikes", 32'(last_strikes), frame_len(DB));
        chk("stall_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // Back-to-back with valid held high
        send_word(8'h11, 32'hCAFEBABE, 1'b1);
        rdy_cnt = 0;
        send_word(8'h22, 32'h01020304, 1'b0);
        wait_idle(1'b0);
        exp_cnt += 16'd2;
        chk("b2b_gap", 32'(last_gap), 2);
        chk("b2b_ready_pulses", 32'(rdy_at_tail), 1);
        chk("b2b_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

        // Randomized frames with random back-pressure
        for (int n = 0; n < 40; n++) begin
            rch = CHW'($urandom);
            rd  = $urandom;
            send_word(rch, rd, 1'b0);
            wait_idle(1'b1);
            exp_cnt++;
            chk("rand_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        end

        // Reset mid-frame, while CSUM is presented
        send_word(8'h5C, 32'hDEADBEEF, 1'b0);
        repeat (DB + 2) begin @(posedge clk); #1; end
        chk("pre_rst_csum", 32'(tx_data), 32'(model_csum(8'h5C, 32'hDEADBEEF)));
        rstn = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_ready", 32'(word_ready), 1);
        chk("midrst_tx_en", 32'(tx_en), 0);
        chk("midrst_tx_data", 32'(tx_data), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_frame_cnt", 32'(frame_cnt), 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        exp_cnt = 16'd0;
        send_word(8'h07, 32'hA1B2C3D4, 1'b0);
        wait_idle(1'b0);
        exp_cnt++;
        chk("postrst_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("postrst_strikes", 32'(last_strikes), frame_len(DB));

        // Counter wrap
        @(posedge clk);
        #1 force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.frame_cnt_q;
        exp_cnt = 16'hFFFF;
        chk("preload_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        send_word(8'h01, 32'h00000001, 1'b0);
        wait_idle(1'b0);
        exp_cnt++;
        chk("wrap_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("wrap_zero", 32'(frame_cnt), 0);

        if (exp_q.size() != 0) fail_now("leftover_bytes");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
